// File: rtl/gol_pkg.sv
// Shared types and width helpers for the Game of Life frame streamer.
package gol_pkg;

    // Streamer control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Row index width; a single-row grid still needs one bit
    function automatic int idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Width able to hold a count of 0..cells inclusive
    function automatic int pop_width(input int cells);
        return $clog2(cells + 1);
    endfunction

endpackage

// File: rtl/gol_row_popcount.sv
// Combinational ones-counter for one grid row.
module gol_row_popcount
    import gol_pkg::*;
#(
    parameter int M = 16
) (
    input  logic [M-1:0]              row,
    output logic [pop_width(M)-1:0]   count
);

    localparam int CW = pop_width(M);

    // Linear sum of the row bits; synthesis folds it into an adder tree
    always_comb begin
        count = '0;
        for (int i = 0; i < M; i++) begin
            count = count + CW'(row[i]);
        end
    end

endmodule

// File: rtl/gol_frame_streamer.sv
// Snapshots the Game of Life grid and streams it out one row per
// valid/ready handshake, row 0 first. The optional live-cell population
// counter is built only when GOL_STREAM_POPCOUNT_EN is defined.
module gol_frame_streamer
    import gol_pkg::*;
#(
    parameter int M = 16,
    parameter int N = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [N*M-1:0]              state_i,
    input  logic                        snap_i,
    output logic                        busy_o,
    output logic                        row_valid_o,
    input  logic                        row_ready_i,
    output logic [M-1:0]                row_data_o,
    output logic [idx_width(N)-1:0]     row_idx_o,
    output logic                        frame_done_o,
    output logic                        drop_o,
    output logic [pop_width(M*N)-1:0]   pop_count_o
);

    localparam int IW = idx_width(N);
    localparam int PW = pop_width(M*N);

    state_t             state;
    state_t             state_nxt;
    logic [N*M-1:0]     shadow;
    logic [IW-1:0]      row_idx;
    logic [M-1:0]       cur_row;
    logic               capture;
    logic               accept;
    logic               last_row;

    // The row mux reads only the shadow copy and the index register, so the
    // outgoing beat is isolated from the live grid and from row_ready_i.
    assign cur_row  = shadow[32'(row_idx) * M +: M];
    assign capture  = (state == IDLE) && snap_i;
    assign accept   = (state == STREAM) && row_ready_i;
    assign last_row = (row_idx == IW'(N - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture -> stream every row -> one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snap_i) state_nxt = STREAM;
            STREAM:  if (row_ready_i && last_row) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; data is forced to zero outside STREAM
    always_comb begin
        busy_o       = (state != IDLE);
        row_valid_o  = (state == STREAM);
        frame_done_o = (state == DONE);
        drop_o       = snap_i && (state != IDLE);
        row_data_o   = (state == STREAM) ? cur_row : '0;
    end

    assign row_idx_o = row_idx;

    // Shadow capture and row index; the index parks on the last row once it
    // has been accepted and is cleared again by the next capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow  <= '0;
            row_idx <= '0;
        end else if (capture) begin
            shadow  <= state_i;
            row_idx <= '0;
        end else if (accept && !last_row) begin
            row_idx <= row_idx + IW'(1);
        end
    end

`ifdef GOL_STREAM_POPCOUNT_EN
    localparam int RW = pop_width(M);

    logic [RW-1:0] row_pop;
    logic [PW-1:0] acc;
    logic [PW-1:0] pop_reg;

    gol_row_popcount #(.M(M)) u_row_popcount (
        .row   (cur_row),
        .count (row_pop)
    );

    // Accumulate each accepted row; publish the total on the DONE cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc     <= '0;
            pop_reg <= '0;
        end else begin
            if (capture) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc + PW'(row_pop);
            end
            if (state == DONE) begin
                pop_reg <= acc;
            end
        end
    end

    // The fresh total is visible during DONE itself, then held
    assign pop_count_o = (state == DONE) ? acc : pop_reg;
`else
    assign pop_count_o = '0;
`endif

endmodule

// File: tb/tb_gol_frame_streamer.sv
// Self-checking bench for gol_frame_streamer: table of frames plus a
// scoreboard of expected row beats, and a hand-written mid-frame reset.
module tb_gol_frame_streamer;

    localparam int M = 16;
    localparam int N = 16;

`ifdef GOL_STREAM_POPCOUNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic [N*M-1:0] state_i;
    logic           snap_i;
    logic           busy_o;
    logic           row_valid_o;
    logic           row_ready_i;
    logic [M-1:0]   row_data_o;
    logic [3:0]     row_idx_o;
    logic           frame_done_o;
    logic           drop_o;
    logic [8:0]     pop_count_o;

    always #5 clk_i = ~clk_i;

    gol_frame_streamer #(.M(M), .N(N)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .state_i      (state_i),
        .snap_i       (snap_i),
        .busy_o       (busy_o),
        .row_valid_o  (row_valid_o),
        .row_ready_i  (row_ready_i),
        .row_data_o   (row_data_o),
        .row_idx_o    (row_idx_o),
        .frame_done_o (frame_done_o),
        .drop_o       (drop_o),
        .pop_count_o  (pop_count_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        string          name;
        logic [N*M-1:0] grid;
        int             stall_row;
        int             stall_len;
        int             drop_at;
        bit             scramble;
        int             exp_pop;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[5];
    int    prev_pop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_pop_of(input int p);
        return POP_EN ? p : 0;
    endfunction

    // Accepted beats are compared against the scoreboard
    initial begin
        beat_t e;
        forever begin
            @(negedge clk_i);
            if (reset_n_i === 1'b1 && row_valid_o === 1'b1 && row_ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 64'(row_idx_o), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("row_idx", 64'(row_idx_o), 64'(e.idx));
                    chk("row_data", 64'(row_data_o), 64'(e.data));
                end
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int    done_k;
        bit    stall;
        beat_t b;
        done_k      = N + 1 + v.stall_len;
        state_i     = v.grid;
        snap_i      = 1'b1;
        row_ready_i = 1'b1;
        @(posedge clk_i); #1;
        snap_i = 1'b0;
        for (int r = 0; r < N; r++) begin
            b.idx  = 4'(r);
            b.data = v.grid[r*M +: M];
            sb.push_back(b);
        end
        for (int k = 1; k <= done_k + 1; k++) begin
            stall = (v.stall_len > 0) && (k >= v.stall_row + 1) && (k <= v.stall_row + v.stall_len);
            row_ready_i = !stall;
            snap_i      = (k == v.drop_at);
            if (v.scramble) state_i = {8{$urandom()}};
            @(negedge clk_i);
            chk({v.name, ".frame_done"}, 64'(frame_done_o), 64'(k == done_k));
            chk({v.name, ".busy"}, 64'(busy_o), 64'(k <= done_k));
            chk({v.name, ".row_valid"}, 64'(row_valid_o), 64'(k < done_k));
            chk({v.name, ".drop"}, 64'(drop_o), 64'(k == v.drop_at));
            if (stall) begin
                chk({v.name, ".stall_idx"}, 64'(row_idx_o), 64'(v.stall_row));
                chk({v.name, ".stall_data"}, 64'(row_data_o), 64'(v.grid[v.stall_row*M +: M]));
            end
            if (k == 1) chk({v.name, ".pop_hold"}, 64'(pop_count_o), 64'(prev_pop));
            @(posedge clk_i); #1;
        end
        snap_i      = 1'b0;
        row_ready_i = 1'b1;
        chk({v.name, ".pop_count"}, 64'(pop_count_o), 64'(exp_pop_of(v.exp_pop)));
        chk({v.name, ".no_restart"}, 64'(busy_o), 64'd0);
        chk({v.name, ".sb_drained"}, 64'(sb.size()), 64'd0);
        prev_pop = exp_pop_of(v.exp_pop);
    endtask

    initial begin
        logic [N*M-1:0] g;

        // Frame table
        g = '0;
        g[1] = 1'b1; g[18] = 1'b1; g[32] = 1'b1; g[33] = 1'b1; g[34] = 1'b1;
        vecs[0] = '{"glider",     g,               0, 0, 0, 1'b0, 5};
        g = {N{16'hA5C3}};
        vecs[1] = '{"backpress",  g,               5, 3, 0, 1'b0, 128};
        g = {N{16'h8001}};
        vecs[2] = '{"isolation",  g,               0, 0, 0, 1'b1, 32};
        g = {N{16'h00F0}};
        vecs[3] = '{"drop",       g,               0, 0, 4, 1'b0, 64};
        g = '1;
        vecs[4] = '{"full",       g,               0, 0, 0, 1'b0, 256};

        // Reset, then idle with everything at zero
        reset_n_i   = 1'b0;
        state_i     = '0;
        snap_i      = 1'b0;
        row_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outs", 64'({busy_o, row_valid_o, row_data_o, row_idx_o, frame_done_o, drop_o, pop_count_o}), 64'd0);
        reset_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("idle_outs", 64'({busy_o, row_valid_o, row_data_o, row_idx_o, frame_done_o, drop_o, pop_count_o}), 64'd0);
        end
        @(posedge clk_i); #1;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // All-ones frame aborted by reset while row 8 is on the bus
        state_i = '1;
        snap_i  = 1'b1;
        @(posedge clk_i); #1;
        snap_i = 1'b0;
        for (int r = 0; r < N; r++) sb.push_back('{4'(r), 16'hFFFF});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            chk("abort.row_valid", 64'(row_valid_o), 64'd1);
            @(posedge clk_i); #1;
        end
        chk("abort.rows_sent", 64'(sb.size()), 64'd8);
        reset_n_i = 1'b0;
        sb.delete();
        #1;
        chk("abort.outs", 64'({busy_o, row_valid_o, frame_done_o, pop_count_o}), 64'd0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("abort.frame_done", 64'(frame_done_o), 64'd0);
            chk("abort.pop_count", 64'(pop_count_o), 64'd0);
            chk("abort.busy", 64'(busy_o), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
